// File: rtl/demux_1x2_ctrl.sv
// rtl/demux_1x2_ctrl.sv - one-word holding demux routing a source to two ready/valid sinks
module demux_1x2_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic             s,
  input  logic             mode,
  output logic             i_ready,
  input  logic [1:0]       y_ready,
  output logic [1:0]       y_valid,
  output logic [WIDTH-1:0] y0_data,
  output logic [WIDTH-1:0] y1_data,
  output logic [CW-1:0]    cnt0,
  output logic [CW-1:0]    cnt1
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             sel_q, sel_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt0_q, cnt0_d;
  logic [CW-1:0]    cnt1_q, cnt1_d;
  logic             busy;

  // Next-state: accept into the holding register in IDLE, release on the selected sink's ready in BUSY
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          hold_d  = i_data;
          sel_d   = mode ? ptr_q : s;
          ptr_d   = mode ? ~ptr_q : ptr_q;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (y_ready[sel_q]) begin
          state_d = IDLE;
          if (sel_q) begin
            cnt1_d = cnt1_q + CW'(1);
          end else begin
            cnt0_d = cnt0_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset wins over any accept or transfer in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      ptr_q   <= 1'b0;
      hold_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  // Outputs decode registered state only, so y_ready never reaches i_ready combinationally
  always_comb begin
    busy    = (state_q == BUSY);
    i_ready = ~busy;
    y_valid = {busy & sel_q, busy & ~sel_q};
    y0_data = (busy & ~sel_q) ? hold_q : '0;
    y1_data = (busy &  sel_q) ? hold_q : '0;
    cnt0    = cnt0_q;
    cnt1    = cnt1_q;
  end

endmodule

// File: tb/tb_demux_1x2_ctrl.sv
// tb/tb_demux_1x2_ctrl.sv - self-checking bench for demux_1x2_ctrl
module tb_demux_1x2_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic       s = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] y_ready = 2'b00;

  logic       i_ready, w_i_ready;
  logic [1:0] y_valid, w_y_valid;
  logic [7:0] y0_data, y1_data, w_y0_data, w_y1_data;
  logic [7:0] cnt0, cnt1;
  logic [1:0] w_cnt0, w_cnt1;

  always #5 clk = ~clk;

  demux_1x2_ctrl #(.WIDTH(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .s(s), .mode(mode),
    .i_ready(i_ready), .y_ready(y_ready), .y_valid(y_valid),
    .y0_data(y0_data), .y1_data(y1_data), .cnt0(cnt0), .cnt1(cnt1)
  );

  demux_1x2_ctrl #(.WIDTH(8), .CW(2)) dut_w (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .s(s), .mode(mode),
    .i_ready(w_i_ready), .y_ready(y_ready), .y_valid(w_y_valid),
    .y0_data(w_y0_data), .y1_data(w_y1_data), .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: at most one word in flight, tagged with its destination
  bit         m_busy = 1'b0;
  logic [7:0] m_word = 8'h00;
  int         m_dest = 0;
  int         m_ptr  = 0;
  int         m_cnt [2] = '{0, 0};
  int         delivered [$];

  task automatic model_check();
    logic [1:0] ev;
    logic [7:0] e0, e1;
    ev = m_busy ? ((m_dest == 1) ? 2'b10 : 2'b01) : 2'b00;
    e0 = (m_busy && m_dest == 0) ? m_word : 8'h00;
    e1 = (m_busy && m_dest == 1) ? m_word : 8'h00;
    chk("i_ready", i_ready, !m_busy);
    chk("y_valid", y_valid, ev);
    chk("y0_data", y0_data, e0);
    chk("y1_data", y1_data, e1);
    chk("cnt0", cnt0, m_cnt[0] % 256);
    chk("cnt1", cnt1, m_cnt[1] % 256);
    chk("w_y_valid", w_y_valid, ev);
    chk("w_cnt0", w_cnt0, m_cnt[0] % 4);
    chk("w_cnt1", w_cnt1, m_cnt[1] % 4);
  endtask

  task automatic model_update();
    if (rst) begin
      m_busy = 1'b0;
      m_word = 8'h00;
      m_ptr  = 0;
      m_cnt  = '{0, 0};
    end else if (!m_busy) begin
      if (i_valid) begin
        m_busy = 1'b1;
        m_word = i_data;
        m_dest = mode ? m_ptr : int'(s);
        if (mode) m_ptr = 1 - m_ptr;
      end
    end else if (y_ready[m_dest]) begin
      m_busy = 1'b0;
      m_cnt[m_dest]++;
      delivered.push_back(m_dest);
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked there before the next rising edge
  task automatic step();
    model_check();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] d;
    logic       s;
    logic       mode;
    logic [1:0] yr;
    logic       rdy;
    logic [1:0] yv;
    logic [7:0] y0;
    logic [7:0] y1;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int exp_wrap [5];
    int exp_order [4];

    //          rst   iv    d      s     mode  yr     rdy   yv     y0     y1     c0     c1
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, 8'h00, 8'h00, 8'd0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 2'b11, 1'b0, 2'b10, 8'h00, 8'hA5, 8'd0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 8'h00, 8'h00, 8'd0, 8'd1};
    tbl[3]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 8'h3C, 8'h00, 8'd0, 8'd1};
    tbl[4]  = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 8'h3C, 8'h00, 8'd0, 8'd1};
    tbl[5]  = '{1'b0, 1'b1, 8'h78, 1'b1, 1'b0, 2'b00, 1'b0, 2'b01, 8'h3C, 8'h00, 8'd0, 8'd1};
    tbl[6]  = '{1'b0, 1'b0, 8'h79, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 8'h3C, 8'h00, 8'd0, 8'd1};
    tbl[7]  = '{1'b0, 1'b1, 8'h7A, 1'b1, 1'b1, 2'b00, 1'b0, 2'b01, 8'h3C, 8'h00, 8'd0, 8'd1};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b10, 1'b0, 2'b01, 8'h3C, 8'h00, 8'd0, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b01, 1'b1, 2'b00, 8'h00, 8'h00, 8'd1, 8'd1};
    tbl[10] = '{1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 2'b11, 1'b1, 2'b00, 8'h00, 8'h00, 8'd0, 8'd0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00, 8'h00, 8'h00, 8'd0, 8'd0};

    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; i_valid = tbl[i].iv; i_data = tbl[i].d;
      s = tbl[i].s; mode = tbl[i].mode; y_ready = tbl[i].yr;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d i_ready", i), i_ready, tbl[i].rdy);
      chk($sformatf("vec%0d y_valid", i), y_valid, tbl[i].yv);
      chk($sformatf("vec%0d y0_data", i), y0_data, tbl[i].y0);
      chk($sformatf("vec%0d y1_data", i), y1_data, tbl[i].y1);
      chk($sformatf("vec%0d cnt0", i), cnt0, tbl[i].c0);
      chk($sformatf("vec%0d cnt1", i), cnt1, tbl[i].c1);
    end
    rst = 1'b0;

    // Ping-pong: four words alternate 0,1,0,1 regardless of s
    do_reset();
    delivered.delete();
    y_ready = 2'b11;
    for (int k = 1; k <= 4; k++) begin
      mode = 1'b1; i_valid = 1'b1; i_data = 8'(k); s = 1'($urandom);
      step();
      mode = 1'($urandom); i_valid = 1'($urandom); i_data = 8'($urandom); s = 1'($urandom);
      step();
    end
    i_valid = 1'b0;
    exp_order = '{0, 1, 0, 1};
    chk("pingpong count", delivered.size(), 4);
    for (int k = 0; k < 4 && k < delivered.size(); k++)
      chk($sformatf("pingpong dest%0d", k), delivered[k], exp_order[k]);
    chk("pingpong cnt0", cnt0, 2);
    chk("pingpong cnt1", cnt1, 2);

    // Mode mix: an explicit accept leaves the ping-pong pointer untouched
    do_reset();
    y_ready = 2'b11;
    mode = 1'b1; i_valid = 1'b1; i_data = 8'h11; step();
    i_valid = 1'b0; step();
    mode = 1'b0; s = 1'b0; i_valid = 1'b1; i_data = 8'h22; step();
    i_valid = 1'b0; step();
    mode = 1'b1; s = 1'b0; i_valid = 1'b1; i_data = 8'h33; step();
    chk("mix third y_valid", y_valid, 2'b10);
    chk("mix third y1_data", y1_data, 8'h33);
    i_valid = 1'b0; step();

    // Counter wrap on the CW=2 instance
    do_reset();
    y_ready = 2'b11;
    exp_wrap = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) begin
      mode = 1'b0; s = 1'b0; i_valid = 1'b1; i_data = 8'(8'hC0 + k); step();
      i_valid = 1'b0; step();
      chk($sformatf("wrap cnt0[%0d]", k), w_cnt0, exp_wrap[k]);
    end

    // Reset while holding a word for channel 1 discards it uncounted
    do_reset();
    y_ready = 2'b00;
    mode = 1'b0; s = 1'b1; i_valid = 1'b1; i_data = 8'hC3; step();
    i_valid = 1'b0; step(); step();
    chk("midrst busy y_valid", y_valid, 2'b10);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("midrst i_ready", i_ready, 1'b1);
    chk("midrst y_valid", y_valid, 2'b00);
    chk("midrst y1_data", y1_data, 8'h00);
    chk("midrst cnt1", cnt1, 0);
    mode = 1'b1; i_valid = 1'b1; i_data = 8'h5A; step();
    chk("midrst next to ch0", y_valid, 2'b01);
    i_valid = 1'b0; y_ready = 2'b11; step();

    // Randomized traffic against the model
    do_reset();
    for (int k = 0; k < 600; k++) begin
      rst     = ($urandom_range(0, 59) == 0);
      i_valid = 1'($urandom);
      i_data  = 8'($urandom);
      s       = 1'($urandom);
      mode    = 1'($urandom);
      y_ready = 2'($urandom);
      step();
    end
    rst = 1'b0;
    model_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
